// File: rtl/vga_ball_display.sv
// 640x480 1bpp framebuffer: Avalon-MM write-only slave into a 9600x32 RAM, scanned out to VGA.
// Latency: RGB lags the scan counters by one clk; backpressure: none, writes always accepted.
module vga_ball_display (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] writedata,
  input  logic        write,
  input  logic        chipselect,
  input  logic [14:0] address,
  output logic [7:0]  VGA_R,
  output logic [7:0]  VGA_G,
  output logic [7:0]  VGA_B,
  output logic        VGA_CLK,
  output logic        VGA_HS,
  output logic        VGA_VS,
  output logic        VGA_BLANK_n,
  output logic        VGA_SYNC_n
);

  localparam int H_ACTIVE       = 640;
  localparam int V_ACTIVE       = 480;
  localparam int WORDS_PER_LINE = 20;
  localparam int FB_WORDS       = WORDS_PER_LINE * V_ACTIVE;
  localparam int H_FP = 32, H_SYNC = 192, H_BP = 96;
  localparam int V_FP = 10, V_SYNC = 2,   V_BP = 33;

  // Horizontal timing is in clk ticks: two ticks per pixel.
  localparam logic [10:0] H_VIS  = 11'(2 * H_ACTIVE);
  localparam logic [10:0] HS_BEG = 11'(2 * H_ACTIVE + H_FP);
  localparam logic [10:0] HS_END = 11'(2 * H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] H_LAST = 11'(2 * H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0]  V_VIS  = 10'(V_ACTIVE);
  localparam logic [9:0]  VS_BEG = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0]  VS_END = 10'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [9:0]  V_LAST = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);

  logic [10:0] hcount;
  logic [9:0]  vcount;
  logic [31:0] mem [FB_WORDS];
  logic [13:0] rd_addr;
  logic [31:0] word_q;
  logic [4:0]  bit_q;
  logic        vis_q;
  logic        visible;
  logic        pixel;

  always_ff @(posedge clk) begin
    if (!reset) begin
      hcount <= '0;
      vcount <= '0;
    end else if (hcount == H_LAST) begin
      hcount <= '0;
      vcount <= (vcount == V_LAST) ? 10'd0 : vcount + 10'd1;
    end else begin
      hcount <= hcount + 11'd1;
    end
  end

  assign visible = (hcount < H_VIS) && (vcount < V_VIS);

  // Blanking-region addresses run past the RAM; the read result is masked by vis_q.
  assign rd_addr = 14'(vcount) * 14'(WORDS_PER_LINE) + 14'(hcount[10:6]);

  // RAM write and registered read share one block so read-during-write returns old data.
  always_ff @(posedge clk) begin
    if (chipselect && write && (address < 15'(FB_WORDS)))
      mem[address[13:0]] <= writedata;
    if (!reset) begin
      word_q <= '0;
      bit_q  <= '0;
      vis_q  <= 1'b0;
    end else begin
      word_q <= mem[rd_addr];
      bit_q  <= hcount[5:1];
      vis_q  <= visible;
    end
  end

  assign pixel       = word_q[bit_q] & vis_q;
  assign VGA_R       = {8{pixel}};
  assign VGA_G       = {8{pixel}};
  assign VGA_B       = {8{pixel}};
  assign VGA_CLK     = hcount[0];
  assign VGA_HS      = !((hcount >= HS_BEG) && (hcount < HS_END));
  assign VGA_VS      = !((vcount >= VS_BEG) && (vcount < VS_END));
  assign VGA_BLANK_n = visible;
  assign VGA_SYNC_n  = 1'b0;

endmodule

// File: tb/tb_vga_ball_display.sv
// Randomized bench for vga_ball_display against a pixel-level framebuffer model.
module tb_vga_ball_display;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] writedata = '0;
  logic        write = 1'b0;
  logic        chipselect = 1'b0;
  logic [14:0] address = '0;
  logic [7:0]  VGA_R, VGA_G, VGA_B;
  logic        VGA_CLK, VGA_HS, VGA_VS, VGA_BLANK_n, VGA_SYNC_n;

  always #10 clk = ~clk;

  vga_ball_display dut (
    .clk(clk), .reset(reset), .writedata(writedata), .write(write),
    .chipselect(chipselect), .address(address),
    .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B), .VGA_CLK(VGA_CLK),
    .VGA_HS(VGA_HS), .VGA_VS(VGA_VS), .VGA_BLANK_n(VGA_BLANK_n), .VGA_SYNC_n(VGA_SYNC_n)
  );

  int n_checks = 0;
  int n_fails  = 0;
  bit pix [0:307199];          // model screen, one entry per pixel, index y*640+x
  logic [10:0] f_hc = '0;
  logic [9:0]  f_vc = '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic bit white(input int x, input int y);
    return ((x / 20) % 2) == ((y / 20) % 2);
  endfunction

  function automatic logic [31:0] cb_word(input int a);
    logic [31:0] w;
    for (int n = 0; n < 32; n++) w[n] = white((a % 20) * 32 + n, a / 20);
    return w;
  endfunction

  function automatic logic [31:0] model_word(input int a);
    logic [31:0] w;
    for (int n = 0; n < 32; n++) w[n] = pix[(a / 20) * 640 + (a % 20) * 32 + n];
    return w;
  endfunction

  task automatic model_store(input int a, input logic [31:0] d);
    for (int n = 0; n < 32; n++) pix[(a / 20) * 640 + (a % 20) * 32 + n] = d[n];
  endtask

  function automatic logic [7:0] pix_rgb(input int hc, input int vc);
    if (hc < 1280 && vc < 480) begin
      if (pix[vc * 640 + hc / 2]) return 8'hFF;
    end
    return 8'h00;
  endfunction

  task automatic bus_write(input int a, input logic [31:0] d, input logic cs, input logic wr);
    address = 15'(a); writedata = d; chipselect = cs; write = wr;
    @(posedge clk); #1;
    chipselect = 1'b0; write = 1'b0;
    if (cs && wr && a < 9600) model_store(a, d);
  endtask

  // Counters must already be forced onto f_hc/f_vc.
  task automatic probe(input int hc, input int vc, input string tag);
    f_hc = 11'(hc); f_vc = 10'(vc);
    @(posedge clk); #1;
    chk(tag, {VGA_R, VGA_G, VGA_B}, {3{pix_rgb(hc, vc)}});
    chk("blank_forced", VGA_BLANK_n, (hc < 1280 && vc < 480));
  endtask

  task automatic probe_visible(input int count);
    repeat (count) probe(2 * $urandom_range(0, 639) + $urandom_range(0, 1), $urandom_range(0, 479), "pix_rand");
  endtask

  // Starts right after the last reset edge, with reset just released.
  task automatic freerun(input int ncyc);
    int hc = 0, vc = 0, hs_low = 0;
    logic [7:0] exp_rgb = 8'h00;
    for (int i = 0; i < ncyc; i++) begin
      chk("hcount", dut.hcount, hc);
      chk("vcount", dut.vcount, vc);
      chk("hs", VGA_HS, !(hc >= 1312 && hc < 1504));
      chk("vs", VGA_VS, !(vc == 490 || vc == 491));
      chk("blank", VGA_BLANK_n, (hc < 1280 && vc < 480));
      chk("vga_clk", VGA_CLK, hc % 2);
      chk("rgb_run", {VGA_R, VGA_G, VGA_B}, {3{exp_rgb}});
      if (VGA_HS === 1'b0) hs_low++;
      exp_rgb = pix_rgb(hc, vc);
      @(posedge clk); #1;
      hc++;
      if (hc == 1600) begin
        chk("hs_low_per_line", hs_low, 192);
        hs_low = 0;
        hc = 0;
        vc = (vc == 524) ? 0 : vc + 1;
      end
    end
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: time limit reached, %0d checks so far", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int a;
    logic [31:0] old;
    repeat (3) @(posedge clk); #1;
    chk("rst_hcount", dut.hcount, 0);
    chk("rst_vcount", dut.vcount, 0);
    chk("rst_rgb", {VGA_R, VGA_G, VGA_B}, 0);
    chk("rst_hs", VGA_HS, 1);
    chk("rst_vs", VGA_VS, 1);
    chk("rst_blank", VGA_BLANK_n, 1);
    chk("rst_vga_clk", VGA_CLK, 0);
    chk("rst_sync_n", VGA_SYNC_n, 0);

    // Checkerboard load while held in reset; RAM writes do not depend on reset.
    for (int i = 0; i < 9600; i++) bus_write(i, cb_word(i), 1'b1, 1'b1);
    bus_write(0, 32'h0, 1'b0, 1'b1);
    bus_write(21, 32'h0, 1'b1, 1'b0);
    chk("rst_hold_hcount", dut.hcount, 0);
    reset = 1'b1;
    freerun(3300);

    force dut.hcount = f_hc;
    force dut.vcount = f_vc;
    for (int v = 0; v < 525; v++) begin
      f_vc = 10'(v);
      f_hc = 11'($urandom_range(0, 1599));
      #1;
      chk("vs_forced", VGA_VS, !(v == 490 || v == 491));
      chk("hs_forced", VGA_HS, !(f_hc >= 1312 && f_hc < 1504));
      chk("blank_vs", VGA_BLANK_n, (f_hc < 1280 && v < 480));
    end
    probe(0, 0, "spot_0_0");
    probe(50, 5, "spot_25_5");
    probe(90, 5, "spot_45_5");
    probe(10, 25, "spot_5_25");
    probe(90, 45, "spot_45_45");
    probe_visible(1200);
    repeat (300) probe($urandom_range(0, 1599), $urandom_range(0, 524), "pix_any");

    // Read and write of the same word in one cycle: old data first, new data next.
    a = 100 * 20 + 7;
    old = model_word(a);
    f_hc = 11'((7 * 32 + 3) * 2); f_vc = 10'd100;
    address = 15'(a); writedata = ~old; chipselect = 1'b1; write = 1'b1;
    @(posedge clk); #1;
    chipselect = 1'b0; write = 1'b0;
    chk("rdw_old", {VGA_R, VGA_G, VGA_B}, {3{old[3] ? 8'hFF : 8'h00}});
    model_store(a, ~old);
    @(posedge clk); #1;
    chk("rdw_new", {VGA_R, VGA_G, VGA_B}, {3{pix_rgb(int'(f_hc), int'(f_vc))}});

    // Frame and line wrap from released counters.
    f_hc = 11'd1599; f_vc = 10'd524; #1;
    release dut.hcount; release dut.vcount;
    @(posedge clk); #1;
    chk("wrap_frame_h", dut.hcount, 0);
    chk("wrap_frame_v", dut.vcount, 0);
    f_hc = 11'd1599; f_vc = 10'd479;
    force dut.hcount = f_hc;
    force dut.vcount = f_vc;
    #1;
    release dut.hcount; release dut.vcount;
    @(posedge clk); #1;
    chk("wrap_line_h", dut.hcount, 0);
    chk("wrap_line_v", dut.vcount, 480);

    bus_write(9600, 32'hFFFF_FFFF, 1'b1, 1'b1);
    bus_write(32767, 32'hFFFF_FFFF, 1'b1, 1'b1);
    bus_write(16389, 32'hFFFF_FFFF, 1'b1, 1'b1);
    bus_write(25000, 32'hFFFF_FFFF, 1'b1, 1'b1);
    force dut.hcount = f_hc;
    force dut.vcount = f_vc;
    probe(10, 0, "oor_word0");
    probe(2 * (5 * 32 + 2), 0, "oor_word5");
    probe_visible(300);

    for (int i = 0; i < 9600; i++) bus_write(i, 32'h0, 1'b1, 1'b1);
    probe_visible(200);
    repeat (200) bus_write($urandom_range(0, 9599), $urandom, 1'b1, 1'b1);
    probe_visible(300);

    release dut.hcount; release dut.vcount;
    repeat (700) @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk); #1;
    chk("midrst_hcount", dut.hcount, 0);
    chk("midrst_vcount", dut.vcount, 0);
    chk("midrst_rgb", {VGA_R, VGA_G, VGA_B}, 0);
    reset = 1'b1;
    freerun(1700);
    force dut.hcount = f_hc;
    force dut.vcount = f_vc;
    probe_visible(300);
    release dut.hcount; release dut.vcount;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
